// File: rtl/frame_parity_checker.sv
// frame_parity_checker: streaming per-word parity and longitudinal (LRC) check.
// A frame is FRAME_LEN data beats followed by one check beat. One result per
// frame is offered on a valid/ready handshake, and a saturating counter tracks
// how many accepted results were bad.
module frame_parity_checker #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned FRAME_LEN = 4,
    parameter int unsigned CNT_W     = 8
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             odd_mode,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [DATA_W-1:0]                in_data,
    input  logic                             in_par,
    output logic                             res_valid,
    input  logic                             res_ready,
    output logic [$clog2(FRAME_LEN+2)-1:0]   res_word_err,
    output logic                             res_lrc_err,
    output logic                             res_ok,
    output logic [CNT_W-1:0]                 err_cnt,
    input  logic                             clr_cnt
);

    localparam int unsigned IDX_W = $clog2(FRAME_LEN + 1);
    localparam int unsigned ERR_W = $clog2(FRAME_LEN + 2);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        REPORT  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [DATA_W-1:0]   acc_q, acc_d;
    logic [ERR_W-1:0]    cnt_q, cnt_d;
    logic                mode_q, mode_d;

    logic                in_ready_d;
    logic                res_valid_d;
    logic [ERR_W-1:0]    word_err_d;
    logic                lrc_err_d;
    logic                ok_d;
    logic [CNT_W-1:0]    err_cnt_d;

    logic                beat_mode;
    logic                word_bad;
    logic [ERR_W-1:0]    total_err;
    logic [DATA_W-1:0]   lrc_expect;
    logic                lrc_bad;

    // Next-state, datapath and result computation
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        mode_d      = mode_q;
        word_err_d  = res_word_err;
        lrc_err_d   = res_lrc_err;
        ok_d        = res_ok;
        err_cnt_d   = err_cnt;

        // Beat 0 uses the live mode input since it is the one being latched
        beat_mode   = (idx_q == '0) ? odd_mode : mode_q;
        word_bad    = (^{in_data, in_par}) ^ beat_mode;
        total_err   = cnt_q + ERR_W'(word_bad);
        lrc_expect  = mode_q ? ~acc_q : acc_q;
        lrc_bad     = (in_data != lrc_expect);

        case (state_q)
            COLLECT: begin
                if (in_valid) begin
                    if (idx_q == '0) begin
                        mode_d = odd_mode;
                    end
                    if (idx_q == LAST_IDX) begin
                        word_err_d = total_err;
                        lrc_err_d  = lrc_bad;
                        ok_d       = (total_err == '0) && !lrc_bad;
                        state_d    = REPORT;
                    end else begin
                        acc_d = acc_q ^ in_data;
                        cnt_d = total_err;
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            REPORT: begin
                if (res_ready) begin
                    state_d = COLLECT;
                    idx_d   = '0;
                    acc_d   = '0;
                    cnt_d   = '0;
                    if (!res_ok && (err_cnt != CNT_MAX)) begin
                        err_cnt_d = err_cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = COLLECT;
            end
        endcase

        // Clear takes priority over a same-edge increment
        if (clr_cnt) begin
            err_cnt_d = '0;
        end

        in_ready_d  = (state_d == COLLECT);
        res_valid_d = (state_d == REPORT);
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= COLLECT;
            idx_q        <= '0;
            acc_q        <= '0;
            cnt_q        <= '0;
            mode_q       <= 1'b0;
            in_ready     <= 1'b1;
            res_valid    <= 1'b0;
            res_word_err <= '0;
            res_lrc_err  <= 1'b0;
            res_ok       <= 1'b0;
            err_cnt      <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            mode_q       <= mode_d;
            in_ready     <= in_ready_d;
            res_valid    <= res_valid_d;
            res_word_err <= word_err_d;
            res_lrc_err  <= lrc_err_d;
            res_ok       <= ok_d;
            err_cnt      <= err_cnt_d;
        end
    end

endmodule

// File: tb/tb_frame_parity_checker.sv
// Testbench for frame_parity_checker: directed plan cases plus random frames
// checked against a parity/LRC model computed from the frame contents.
module tb_frame_parity_checker;

    localparam int unsigned DW = 8;
    localparam int unsigned FL = 4;
    localparam int unsigned CW = 2;
    localparam int unsigned EW = $clog2(FL + 2);
    localparam int unsigned CNT_SAT = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          odd_mode;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          in_par;
    logic          res_valid;
    logic          res_ready;
    logic [EW-1:0] res_word_err;
    logic          res_lrc_err;
    logic          res_ok;
    logic [CW-1:0] err_cnt;
    logic          clr_cnt;

    int tests = 0;
    int fails = 0;
    int exp_cnt = 0;

    logic [DW-1:0] fd [FL+1];
    logic          fp [FL+1];

    frame_parity_checker #(.DATA_W(DW), .FRAME_LEN(FL), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .odd_mode(odd_mode),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_par(in_par),
        .res_valid(res_valid), .res_ready(res_ready), .res_word_err(res_word_err),
        .res_lrc_err(res_lrc_err), .res_ok(res_ok), .err_cnt(err_cnt), .clr_cnt(clr_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_beat(input int i, input logic [DW-1:0] d, input logic p);
        fd[i] = d;
        fp[i] = p;
    endtask

    // Fill the frame with random data; parity and check word usually correct
    task automatic rand_frame(input logic odd);
        logic [DW-1:0] col;
        col = '0;
        for (int i = 0; i < FL; i++) begin
            fd[i] = DW'($urandom);
            col   = col ^ fd[i];
        end
        fd[FL] = odd ? ~col : col;
        if ($urandom_range(0, 3) == 0) fd[FL] = fd[FL] ^ DW'(1 << $urandom_range(0, DW - 1));
        for (int i = 0; i <= FL; i++) begin
            fp[i] = 1'(($countones(fd[i]) + (odd ? 1 : 0)) % 2);
            if ($urandom_range(0, 7) == 0) fp[i] = ~fp[i];
        end
    endtask

    // Send the frame, hold the result for 'hold' cycles, then accept it
    task automatic run_frame(input string name, input logic odd, input int hold, input logic clr);
        int            exp_werr;
        logic          exp_lerr;
        logic          exp_ok;
        logic [DW-1:0] col;
        exp_werr = 0;
        col = '0;
        for (int i = 0; i <= FL; i++)
            if (($countones({fd[i], fp[i]}) % 2) != (odd ? 1 : 0)) exp_werr++;
        for (int i = 0; i < FL; i++) col = col ^ fd[i];
        exp_lerr = odd ? (fd[FL] != ~col) : (fd[FL] != col);
        exp_ok   = (exp_werr == 0) && !exp_lerr;

        for (int i = 0; i <= FL; i++) begin
            @(negedge clk);
            chk({name, " in_ready"}, 32'(in_ready), 32'd1);
            chk({name, " res_valid idle"}, 32'(res_valid), 32'd0);
            in_valid  = 1'b1;
            in_data   = fd[i];
            in_par    = fp[i];
            odd_mode  = (i == 0) ? odd : 1'($urandom);
            res_ready = 1'($urandom);
        end
        // Beats offered while the result is pending must be ignored
        @(negedge clk);
        in_data   = 8'hAA;
        in_par    = 1'($urandom);
        res_ready = 1'b0;
        for (int h = 0; h <= hold; h++) begin
            if (h > 0) @(negedge clk);
            chk({name, " res_valid"}, 32'(res_valid), 32'd1);
            chk({name, " in_ready low"}, 32'(in_ready), 32'd0);
            chk({name, " word_err"}, 32'(res_word_err), 32'(exp_werr));
            chk({name, " lrc_err"}, 32'(res_lrc_err), 32'(exp_lerr));
            chk({name, " ok"}, 32'(res_ok), 32'(exp_ok));
            chk({name, " err_cnt hold"}, 32'(err_cnt), 32'(exp_cnt));
        end
        res_ready = 1'b1;
        clr_cnt   = clr;
        @(negedge clk);
        if (clr) exp_cnt = 0;
        else if (!exp_ok && exp_cnt < CNT_SAT) exp_cnt++;
        in_valid  = 1'b0;
        res_ready = 1'b0;
        clr_cnt   = 1'b0;
        chk({name, " res_valid after"}, 32'(res_valid), 32'd0);
        chk({name, " in_ready after"}, 32'(in_ready), 32'd1);
        chk({name, " err_cnt"}, 32'(err_cnt), 32'(exp_cnt));
    endtask

    task automatic check_reset_vals(input string name);
        chk({name, " in_ready"}, 32'(in_ready), 32'd1);
        chk({name, " res_valid"}, 32'(res_valid), 32'd0);
        chk({name, " word_err"}, 32'(res_word_err), 32'd0);
        chk({name, " lrc_err"}, 32'(res_lrc_err), 32'd0);
        chk({name, " ok"}, 32'(res_ok), 32'd0);
        chk({name, " err_cnt"}, 32'(err_cnt), 32'd0);
    endtask

    task automatic even_good;
        set_beat(0, 8'h01, 1'b1);
        set_beat(1, 8'h02, 1'b1);
        set_beat(2, 8'h04, 1'b1);
        set_beat(3, 8'h08, 1'b1);
        set_beat(4, 8'h0F, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; odd_mode = 1'b0; in_valid = 1'b0; in_data = '0;
        in_par = 1'b0; res_ready = 1'b0; clr_cnt = 1'b0;
        #12;
        check_reset_vals("reset");
        @(negedge clk);
        rst_n = 1'b1;

        even_good();
        run_frame("even_good", 1'b0, 0, 1'b0);

        even_good();
        set_beat(2, 8'h04, 1'b0);
        run_frame("word_err", 1'b0, 0, 1'b0);

        for (int i = 0; i < FL; i++) set_beat(i, 8'h00, 1'b1);
        set_beat(FL, 8'hFF, 1'b1);
        run_frame("odd_good", 1'b1, 0, 1'b0);

        even_good();
        set_beat(4, 8'h0E, 1'b1);
        run_frame("lrc_err", 1'b0, 0, 1'b0);

        even_good();
        run_frame("backpressure", 1'b0, 5, 1'b0);

        for (int n = 0; n < 5; n++) begin
            even_good();
            set_beat(1, 8'h02, 1'b0);
            run_frame("saturate", 1'b0, 0, 1'b0);
        end
        chk("sat value", 32'(err_cnt), 32'(CNT_SAT));

        even_good();
        set_beat(0, 8'h01, 1'b0);
        run_frame("clr_wins", 1'b0, 0, 1'b1);

        // Partial frame then asynchronous reset
        even_good();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = fd[i]; in_par = fp[i]; odd_mode = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        exp_cnt = 0;
        check_reset_vals("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        even_good();
        run_frame("post_reset", 1'b0, 0, 1'b0);

        for (int n = 0; n < 60; n++) begin
            logic odd;
            odd = 1'($urandom);
            rand_frame(odd);
            run_frame("random", odd, $urandom_range(0, 3), 1'($urandom_range(0, 9) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
